// File: rtl/vga_sync_gen_pkg.sv
// vga_timing_pkg: SVGA 800x600@72 default timing, derived sync windows and the coordinate type
package vga_timing_pkg;
  localparam int CW = 11;
  localparam int H_DISP = 800;
  localparam int H_FP = 56;
  localparam int H_SYNC = 120;
  localparam int H_BP = 64;
  localparam int V_DISP = 600;
  localparam int V_FP = 37;
  localparam int V_SYNC = 6;
  localparam int V_BP = 23;
  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_DISP + H_FP;
  localparam int HS_END = HS_START + H_SYNC - 1;
  localparam int VS_START = V_DISP + V_FP;
  localparam int VS_END = VS_START + V_SYNC - 1;
  typedef logic [CW-1:0] coord_t;
endpackage

// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: raster timing bundle; master = generator, slave = pixel consumer
import vga_timing_pkg::*;
interface vga_sync_gen_if;
  logic hsync;
  logic vsync;
  logic video_on;
  coord_t pix_x;
  coord_t pix_y;
  logic p_tick;
  logic frame_start;
  logic [15:0] frame_cnt;
  modport master(output hsync, vsync, video_on, pix_x, pix_y, p_tick, frame_start, frame_cnt);
  modport slave(input hsync, vsync, video_on, pix_x, pix_y, p_tick, frame_start, frame_cnt);
endinterface

// File: rtl/vga_pix_tick.sv
// vga_pix_tick: clk/CLK_DIV divider; p_tick (registered) is high one clk in every CLK_DIV, ports clk, reset, p_tick
module vga_pix_tick #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);
  localparam logic [1:0] D_LAST = 2'(CLK_DIV - 1);
  logic [1:0] div;
  always_ff @(posedge clk) begin
    if (reset) begin
      div <= '0;
      p_tick <= 1'b0;
    end else begin
      div <= (div == D_LAST) ? '0 : div + 2'd1;
      p_tick <= div == D_LAST;
    end
  end
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster timing generator; ports clk, reset, vga (master: hsync/vsync/video_on/pix_x/pix_y/p_tick/frame_start/frame_cnt); VGA_FRAME_CNT_EN enables frame_cnt
module vga_sync_gen import vga_timing_pkg::CW; #(
  parameter int H_DISP = vga_timing_pkg::H_DISP,
  parameter int H_FP = vga_timing_pkg::H_FP,
  parameter int H_SYNC = vga_timing_pkg::H_SYNC,
  parameter int H_BP = vga_timing_pkg::H_BP,
  parameter int V_DISP = vga_timing_pkg::V_DISP,
  parameter int V_FP = vga_timing_pkg::V_FP,
  parameter int V_SYNC = vga_timing_pkg::V_SYNC,
  parameter int V_BP = vga_timing_pkg::V_BP,
  parameter logic SYNC_POL = 1'b1,
  parameter int CLK_DIV = 1
) (
  input logic clk,
  input logic reset,
  vga_sync_gen_if.master vga
);
  localparam logic [CW-1:0] X_LAST = CW'(H_DISP + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(V_DISP + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CW-1:0] HS_S = CW'(H_DISP + H_FP);
  localparam logic [CW-1:0] HS_E = CW'(H_DISP + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_S = CW'(V_DISP + V_FP);
  localparam logic [CW-1:0] VS_E = CW'(V_DISP + V_FP + V_SYNC - 1);
  localparam logic [CW-1:0] XD = CW'(H_DISP);
  localparam logic [CW-1:0] YD = CW'(V_DISP);
  logic p_tick;
  logic [CW-1:0] x, y, nx, ny;
  logic hs, vs, von, fs;
  logic new_frame;
  vga_pix_tick #(.CLK_DIV(CLK_DIV)) u_tick (.clk(clk), .reset(reset), .p_tick(p_tick));
  // Decode from the next-state counters so sync/video registers line up with pix_x/pix_y.
  always_comb begin
    nx = (x == X_LAST) ? '0 : x + 1'b1;
    ny = (x != X_LAST) ? y : (y == Y_LAST) ? '0 : y + 1'b1;
    new_frame = p_tick && nx == '0 && ny == '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      x <= X_LAST;
      y <= Y_LAST;
      hs <= ~SYNC_POL;
      vs <= ~SYNC_POL;
      von <= 1'b0;
      fs <= 1'b0;
    end else begin
      fs <= new_frame;
      if (p_tick) begin
        x <= nx;
        y <= ny;
        hs <= (nx >= HS_S && nx <= HS_E) ? SYNC_POL : ~SYNC_POL;
        vs <= (ny >= VS_S && ny <= VS_E) ? SYNC_POL : ~SYNC_POL;
        von <= nx < XD && ny < YD;
      end
    end
  end
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] fcnt;
  always_ff @(posedge clk) begin
    if (reset) fcnt <= '0;
    else if (new_frame) fcnt <= fcnt + 16'd1;
  end
  assign vga.frame_cnt = fcnt;
`else
  assign vga.frame_cnt = '0;
`endif
  assign vga.pix_x = x;
  assign vga.pix_y = y;
  assign vga.hsync = hs;
  assign vga.vsync = vs;
  assign vga.video_on = von;
  assign vga.p_tick = p_tick;
  assign vga.frame_start = fs;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed checks of full SVGA line timing plus a reduced-size raster for frame, divider and reset behaviour
module tb_vga_sync_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst1 = 1'b1, rst2 = 1'b1, rst3 = 1'b1;
  int n_run = 0, n_fail = 0;
`ifdef VGA_FRAME_CNT_EN
  localparam int FC = 1;
`else
  localparam int FC = 0;
`endif
  vga_sync_gen_if v1();
  vga_sync_gen_if v2();
  vga_sync_gen_if v3();
  vga_sync_gen u1 (.clk(clk), .reset(rst1), .vga(v1));
  // 16x10 raster: H 8+2+3+3, V 6+1+2+1, hsync x=10..12, vsync y=7..8, frame 160 clk
  vga_sync_gen #(.H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_DISP(6), .V_FP(1), .V_SYNC(2), .V_BP(1))
    u2 (.clk(clk), .reset(rst2), .vga(v2));
  vga_sync_gen #(.H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_DISP(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .CLK_DIV(2))
    u3 (.clk(clk), .reset(rst3), .vga(v3));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_x1(input int tx);
    int k = 0;
    while (v1.pix_x != tx && k < 2000) begin
      cyc(1);
      k++;
    end
    check("reach_x", v1.pix_x, tx);
  endtask
  // Counts clk from the current frame_start to the next one, plus vsync-high cycles in between.
  task automatic frame2(input string tag, input logic use3, output int per, output int vs, output int px, output int py);
    per = 0; vs = 0; px = 0; py = 0;
    do begin
      px = use3 ? v3.pix_x : v2.pix_x;
      py = use3 ? v3.pix_y : v2.pix_y;
      cyc(1);
      per++;
      vs += use3 ? int'(v3.vsync) : int'(v2.vsync);
    end while (!(use3 ? v3.frame_start : v2.frame_start) && per < 1000);
    check({tag, "_bound"}, per < 1000, 1);
  endtask
  initial begin
    int per, vs, px, py, k;
    cyc(2);
    check("rst_x", v1.pix_x, 1039);
    check("rst_y", v1.pix_y, 665);
    check("rst_von", v1.video_on, 0);
    check("rst_hs", v1.hsync, 0);
    check("rst_vs", v1.vsync, 0);
    check("rst_tick", v1.p_tick, 0);
    check("rst_fs", v1.frame_start, 0);
    check("rst_fc", v1.frame_cnt, 0);
    rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
    cyc(1);
    check("tick_on", v1.p_tick, 1);
    check("hold_x", v1.pix_x, 1039);
    check("div2_t0", v3.p_tick, 0);
    cyc(1);
    check("first_x", v1.pix_x, 0);
    check("first_y", v1.pix_y, 0);
    check("first_von", v1.video_on, 1);
    check("first_fs", v1.frame_start, 1);
    check("div2_t1", v3.p_tick, 1);
    check("div2_hold", v3.pix_x, 15);
    cyc(1);
    check("fs_drop", v1.frame_start, 0);
    check("x_one", v1.pix_x, 1);
    check("div2_t2", v3.p_tick, 0);
    check("div2_x0", v3.pix_x, 0);
    check("div2_fs", v3.frame_start, 1);
    cyc(1);
    check("div2_t3", v3.p_tick, 1);
    check("div2_x0b", v3.pix_x, 0);
    check("div2_fs1", v3.frame_start, 0);
    cyc(1);
    check("div2_x1", v3.pix_x, 1);
    wait_x1(799);
    check("von_799", v1.video_on, 1);
    check("hs_799", v1.hsync, 0);
    cyc(1);
    check("von_800", v1.video_on, 0);
    wait_x1(855);
    check("hs_855", v1.hsync, 0);
    cyc(1);
    check("hs_856", v1.hsync, 1);
    wait_x1(975);
    check("hs_975", v1.hsync, 1);
    cyc(1);
    check("hs_976", v1.hsync, 0);
    wait_x1(1039);
    check("y_1039", v1.pix_y, 0);
    check("von_1039", v1.video_on, 0);
    cyc(1);
    check("wrap_x", v1.pix_x, 0);
    check("wrap_y", v1.pix_y, 1);
    check("von_line1", v1.video_on, 1);
    check("vs_line1", v1.vsync, 0);
    k = 0;
    while (!(v2.pix_x == 5 && v2.pix_y == 4) && k < 400) begin
      cyc(1);
      k++;
    end
    check("mid_reach", k < 400, 1);
    check("mid_von", v2.video_on, 1);
    rst2 = 1'b1;
    cyc(1);
    check("mid_rst_x", v2.pix_x, 15);
    check("mid_rst_y", v2.pix_y, 9);
    check("mid_rst_von", v2.video_on, 0);
    check("mid_rst_hs", v2.hsync, 0);
    check("mid_rst_fc", v2.frame_cnt, 0);
    cyc(2);
    rst2 = 1'b0;
    cyc(1);
    check("mid_hold_x", v2.pix_x, 15);
    cyc(1);
    check("mid_x0", v2.pix_x, 0);
    check("mid_y0", v2.pix_y, 0);
    check("mid_fs", v2.frame_start, 1);
    check("fc1", v2.frame_cnt, FC * 1);
    frame2("f2a", 1'b0, per, vs, px, py);
    check("period_16x10", per, 160);
    check("vsync_clks", vs, 32);
    check("pre_wrap_x", px, 15);
    check("pre_wrap_y", py, 9);
    check("fc2", v2.frame_cnt, FC * 2);
    frame2("f2b", 1'b0, per, vs, px, py);
    check("period_16x10b", per, 160);
    check("fc3", v2.frame_cnt, FC * 3);
    cyc(5);
    check("fc3_hold", v2.frame_cnt, FC * 3);
    k = 0;
    while (!v3.frame_start && k < 400) begin
      cyc(1);
      k++;
    end
    check("div2_reach_fs", k < 400, 1);
    frame2("f3", 1'b1, per, vs, px, py);
    check("period_div2", per, 320);
    check("vsync_div2", vs, 64);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
